// File: rtl/mips_multicycle_ctrl.sv
// mips_multicycle_ctrl: main control FSM sequencing fetch/decode/execute/memory/writeback for the multicycle MIPS core
module mips_multicycle_ctrl #(
    parameter int MEM_WAIT_MAX = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       Zero,
    input  logic       overflow,
    input  logic       mem_ready,
    output logic [1:0] ALUOp,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic       IorD,
    output logic       mem_read,
    output logic       mem_write,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic [1:0] PCSrc,
    output logic       pc_en,
    output logic       exc_ovf,
    output logic       exc_ill,
    output logic       bus_err,
    output logic [3:0] state
);
    localparam int CW = $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [3:0] {
        RST = 4'd0, FETCH = 4'd1, DECODE = 4'd2, MEMADR = 4'd3, MEMRD = 4'd4,
        MEMWB = 4'd5, MEMWR = 4'd6, EXEC = 4'd7, ALUWB = 4'd8, BRANCH = 4'd9,
        ADDIEX = 4'd10, ADDIWB = 4'd11, JUMP = 4'd12, ILL = 4'd13
    } state_t;

    state_t        cur, nxt;
    logic [CW-1:0] cnt;
    logic          ovf_q, mem_st, timeout, funct_unused;

    assign funct_unused = ^funct;
    assign state        = cur;
    assign mem_st       = cur == FETCH || cur == MEMRD || cur == MEMWR;
    assign timeout      = mem_st && !mem_ready && cnt == CW'(MEM_WAIT_MAX - 1);

    // state register
    always_ff @(posedge clk or posedge reset)
        if (reset) cur <= RST;
        else       cur <= nxt;

    // memory wait counter restarts on every state change or timeout; overflow latched at the end of the ALU step
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            cnt   <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt <= (nxt != cur || timeout) ? '0 : (mem_st && !mem_ready) ? cnt + 1'b1 : cnt;
            if (cur == EXEC || cur == ADDIEX) ovf_q <= overflow;
        end

    // next-state logic
    always_comb begin
        nxt = FETCH;
        case (cur)
            FETCH:  nxt = mem_ready ? DECODE : FETCH;
            DECODE: case (opcode)
                6'b100011, 6'b101011: nxt = MEMADR;
                6'b000000:            nxt = EXEC;
                6'b000100, 6'b000101: nxt = BRANCH;
                6'b001000:            nxt = ADDIEX;
                6'b000010:            nxt = JUMP;
                default:              nxt = ILL;
            endcase
            MEMADR: nxt = opcode == 6'b100011 ? MEMRD : MEMWR;
            MEMRD:  nxt = mem_ready ? MEMWB : timeout ? FETCH : MEMRD;
            MEMWR:  nxt = (mem_ready || timeout) ? FETCH : MEMWR;
            EXEC:   nxt = ALUWB;
            ADDIEX: nxt = ADDIWB;
            default: nxt = FETCH;
        endcase
    end

    // control outputs decoded from state, qualified by handshake, branch flag and latched overflow
    always_comb begin
        ALUOp = 2'b00; ALUSrcA = 1'b0; ALUSrcB = 2'b00; IorD = 1'b0;
        mem_read = 1'b0; mem_write = 1'b0; IRWrite = 1'b0; RegDst = 1'b0;
        MemtoReg = 1'b0; RegWrite = 1'b0; PCSrc = 2'b00; pc_en = 1'b0;
        exc_ovf = 1'b0; exc_ill = 1'b0; bus_err = 1'b0;
        case (cur)
            FETCH: begin
                mem_read = 1'b1; ALUSrcB = 2'b01; ALUOp = 2'b01;
                IRWrite = mem_ready; pc_en = mem_ready; bus_err = timeout;
            end
            DECODE: begin ALUSrcB = 2'b11; ALUOp = 2'b01; end
            MEMADR, ADDIEX: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = 2'b01; end
            MEMRD: begin mem_read = 1'b1; IorD = 1'b1; bus_err = timeout; end
            MEMWB: begin RegWrite = 1'b1; MemtoReg = 1'b1; end
            MEMWR: begin mem_write = !timeout; IorD = 1'b1; bus_err = timeout; end
            EXEC:  ALUSrcA = 1'b1;
            ALUWB: begin RegDst = 1'b1; RegWrite = !ovf_q; exc_ovf = ovf_q; end
            ADDIWB: begin RegWrite = !ovf_q; exc_ovf = ovf_q; end
            BRANCH: begin
                ALUSrcA = 1'b1; PCSrc = 2'b01;
                ALUOp = opcode[0] ? 2'b11 : 2'b10; pc_en = Zero ^ opcode[0];
            end
            JUMP: begin PCSrc = 2'b10; pc_en = 1'b1; end
            ILL:  exc_ill = 1'b1;
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb_mips_multicycle_ctrl: scoreboard bench walking each instruction class through the control FSM
module tb_mips_multicycle_ctrl;
    logic clk = 1'b0, reset = 1'b1;
    logic [5:0] opcode = 6'd0, funct = 6'd0;
    logic Zero = 1'b0, overflow = 1'b0, mem_ready = 1'b0;
    logic [1:0] ALUOp, ALUSrcB, PCSrc;
    logic ALUSrcA, IorD, mem_read, mem_write, IRWrite, RegDst, MemtoReg, RegWrite, pc_en, exc_ovf, exc_ill, bus_err;
    logic [3:0] state;
    logic [17:0] outs;
    int checks = 0, errors = 0;

    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000, BEQ = 6'b000100,
                           BNE = 6'b000101, ADDI = 6'b001000, J = 6'b000010, BAD = 6'b111111;

    typedef struct {logic [5:0] op; logic mr, z, ov; logic [3:0] st; logic [17:0] cw;} item_t;
    item_t sb[$];

    always #5 clk = ~clk;

    assign outs = {ALUOp, ALUSrcA, ALUSrcB, IorD, mem_read, mem_write, IRWrite, RegDst, MemtoReg,
                   RegWrite, PCSrc, pc_en, exc_ovf, exc_ill, bus_err};

    mips_multicycle_ctrl #(.MEM_WAIT_MAX(16)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .Zero(Zero), .overflow(overflow),
        .mem_ready(mem_ready), .ALUOp(ALUOp), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .IorD(IorD),
        .mem_read(mem_read), .mem_write(mem_write), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .PCSrc(PCSrc), .pc_en(pc_en), .exc_ovf(exc_ovf),
        .exc_ill(exc_ill), .bus_err(bus_err), .state(state)
    );

    // expected control word: ALUOp,ALUSrcA,ALUSrcB,IorD,mem_read,mem_write,IRWrite,RegDst,MemtoReg,RegWrite,PCSrc,pc_en,exc_ovf,exc_ill,bus_err
    function automatic logic [17:0] cw(logic [3:0] s, logic mr, logic z, logic oq, logic bne, logic to);
        case (s)
            4'd1:  return {2'b01, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, mr, 1'b0, 1'b0, 1'b0, 2'b00, mr, 1'b0, 1'b0, to};
            4'd2:  return {2'b01, 1'b0, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd3:  return {2'b01, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd4:  return {2'b00, 1'b0, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, to};
            4'd5:  return {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd6:  return {2'b00, 1'b0, 2'b00, 1'b1, 1'b0, ~to, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, to};
            4'd7:  return {2'b00, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd8:  return {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, ~oq, 2'b00, 1'b0, oq, 1'b0, 1'b0};
            4'd9:  return {bne ? 2'b11 : 2'b10, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, bne ? ~z : z, 1'b0, 1'b0, 1'b0};
            4'd10: return {2'b01, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
            4'd11: return {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, ~oq, 2'b00, 1'b0, oq, 1'b0, 1'b0};
            4'd12: return {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 1'b1, 1'b0, 1'b0, 1'b0};
            4'd13: return {2'b00, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0};
            default: return 18'd0;
        endcase
    endfunction

    function automatic item_t it(logic [5:0] op, logic [3:0] s, logic mr, logic z, logic ov, logic oq, logic to);
        return '{op, mr, z, ov, s, cw(s, mr, z, oq, op == BNE, to)};
    endfunction

    // drive one cycle of stimulus at the falling edge and record what the DUT must show for it
    task automatic step(input item_t x);
        @(negedge clk);
        opcode = x.op; mem_ready = x.mr; Zero = x.z; overflow = x.ov;
        sb.push_back(x);
        #1;
    endtask

    task automatic test_reset();
        opcode = LW; mem_ready = 1'b1; Zero = 1'b1; overflow = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (i == 3) reset = 1'b0;
            #1;
            checks++;
            if ({state, outs} !== 22'd0) begin
                errors++;
                $display("FAIL reset[%0d]: state=%0d ctrl=%b, expected state=0 ctrl=0", i, state, outs);
            end
        end
    endtask

    task automatic test_lw();
        item_t seq[$], e;
        seq = '{it(LW, 1, 1, 0, 0, 0, 0), it(LW, 2, 1, 0, 0, 0, 0), it(LW, 3, 1, 0, 0, 0, 0),
                it(LW, 4, 1, 0, 0, 0, 0), it(LW, 5, 1, 0, 0, 0, 0)};
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL lw[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
    endtask

    task automatic test_sw();
        item_t seq[$], e;
        seq = '{it(SW, 1, 1, 0, 0, 0, 0), it(SW, 2, 1, 0, 0, 0, 0), it(SW, 3, 1, 0, 0, 0, 0),
                it(SW, 6, 1, 0, 0, 0, 0)};
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL sw[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
    endtask

    task automatic test_rtype_ovf();
        item_t seq[$], e;
        seq = '{it(RT, 1, 1, 0, 0, 0, 0), it(RT, 2, 1, 0, 0, 0, 0), it(RT, 7, 1, 0, 1, 0, 0), it(RT, 8, 1, 0, 0, 1, 0),
                it(RT, 1, 1, 0, 1, 0, 0), it(RT, 2, 1, 0, 1, 0, 0), it(RT, 7, 1, 0, 0, 0, 0), it(RT, 8, 1, 0, 1, 0, 0)};
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL rtype[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
    endtask

    task automatic test_addi();
        item_t seq[$], e;
        seq = '{it(ADDI, 1, 1, 0, 0, 0, 0), it(ADDI, 2, 1, 0, 0, 0, 0), it(ADDI, 10, 1, 0, 1, 0, 0), it(ADDI, 11, 1, 0, 0, 1, 0),
                it(ADDI, 1, 1, 0, 0, 0, 0), it(ADDI, 2, 1, 0, 0, 0, 0), it(ADDI, 10, 1, 0, 0, 0, 0), it(ADDI, 11, 1, 0, 0, 0, 0)};
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL addi[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
    endtask

    task automatic test_branch();
        item_t seq[$], e;
        seq = '{it(BEQ, 1, 1, 0, 0, 0, 0), it(BEQ, 2, 1, 0, 0, 0, 0), it(BEQ, 9, 1, 1, 0, 0, 0),
                it(BNE, 1, 1, 0, 0, 0, 0), it(BNE, 2, 1, 0, 0, 0, 0), it(BNE, 9, 1, 1, 0, 0, 0),
                it(BNE, 1, 1, 0, 0, 0, 0), it(BNE, 2, 1, 0, 0, 0, 0), it(BNE, 9, 1, 0, 0, 0, 0),
                it(BEQ, 1, 1, 0, 0, 0, 0), it(BEQ, 2, 1, 0, 0, 0, 0), it(BEQ, 9, 1, 0, 0, 0, 0)};
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL branch[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
    endtask

    task automatic test_jump_ill();
        item_t seq[$], e;
        seq = '{it(J, 1, 1, 0, 0, 0, 0), it(J, 2, 1, 0, 0, 0, 0), it(J, 12, 1, 0, 0, 0, 0),
                it(BAD, 1, 1, 0, 0, 0, 0), it(BAD, 2, 1, 0, 0, 0, 0), it(BAD, 13, 1, 0, 0, 0, 0)};
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL jump_ill[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
    endtask

    task automatic test_mem_wait();
        item_t seq[$], e;
        seq = '{it(LW, 1, 0, 0, 0, 0, 0), it(LW, 1, 0, 0, 0, 0, 0), it(LW, 1, 0, 0, 0, 0, 0), it(LW, 1, 1, 0, 0, 0, 0),
                it(LW, 2, 1, 0, 0, 0, 0), it(LW, 3, 1, 0, 0, 0, 0), it(LW, 4, 0, 0, 0, 0, 0), it(LW, 4, 0, 0, 0, 0, 0),
                it(LW, 4, 1, 0, 0, 0, 0), it(LW, 5, 1, 0, 0, 0, 0)};
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL mem_wait[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
    endtask

    task automatic test_timeout();
        item_t seq[$], e;
        for (int k = 0; k < 16; k++) seq.push_back(it(J, 1, 0, 0, 0, 0, k == 15));
        seq.push_back(it(J, 1, 1, 0, 0, 0, 0));
        seq.push_back(it(J, 2, 1, 0, 0, 0, 0));
        seq.push_back(it(J, 12, 1, 0, 0, 0, 0));
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL timeout[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
    endtask

    task automatic test_async_reset();
        item_t seq[$], e;
        seq = '{it(SW, 1, 1, 0, 0, 0, 0), it(SW, 2, 1, 0, 0, 0, 0), it(SW, 3, 1, 0, 0, 0, 0), it(SW, 6, 0, 0, 0, 0, 0)};
        foreach (seq[i]) begin
            step(seq[i]);
            e = sb.pop_front();
            checks++;
            if ({state, outs} !== {e.st, e.cw}) begin
                errors++;
                $display("FAIL async_pre[%0d]: state=%0d ctrl=%b, expected state=%0d ctrl=%b", i, state, outs, e.st, e.cw);
            end
        end
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({state, outs} !== 22'd0) begin
            errors++;
            $display("FAIL async_abort: state=%0d ctrl=%b mem_write=%b, expected all 0 before any edge", state, outs, mem_write);
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if ({state, outs} !== 22'd0) begin
            errors++;
            $display("FAIL async_rst_state: state=%0d ctrl=%b, expected state=0 ctrl=0", state, outs);
        end
        @(negedge clk);
        #1;
        checks++;
        if (state !== 4'd1) begin
            errors++;
            $display("FAIL async_refetch: state=%0d, expected 1", state);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw();
        test_rtype_ovf();
        test_addi();
        test_branch();
        test_jump_ill();
        test_mem_wait();
        test_timeout();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
